// File: rtl/fpga_link_receiver.sv
// Burst receiver for a toggle-strobe async link: synchronises req/strobe,
// admits a burst only when the FIFO has room, and buffers words in a FWFT FIFO.
module fpga_link_receiver #(
   parameter int DATA_WIDTH     = 32,
   parameter int BURST_LEN      = 10,
   parameter int FIFO_DEPTH     = 16,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_WIDTH-1:0]         data_in,
   input  logic                          req_in,
   input  logic                          strb_in,
   output logic                          rdy_out,
   output logic                          ack_out,
   output logic [DATA_WIDTH-1:0]         data_out,
   output logic                          valid_out,
   input  logic                          ready_in,
   output logic                          burst_done,
   output logic [1:0]                    err_out,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(BURST_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RECEIVE = 2'd1,
      ACK     = 2'd2,
      ERROR   = 2'd3
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] req_sync;
   logic [SYNC_STAGES-1:0] strb_sync;
   logic                   req_s;
   logic                   strb_s;
   logic                   strb_d;
   logic                   strb_edge;
   logic [CW-1:0]          wrd_cnt;
   logic [TW-1:0]          tmo_cnt;
   logic                   space_ok;

   logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic                   push;
   logic                   pop;

   // ------------------------------------------------------------------
   // Synchronisers and strobe edge detect
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_sync  <= '0;
         strb_sync <= '0;
         strb_d    <= 1'b0;
      end else begin
         req_sync  <= {req_sync[SYNC_STAGES-2:0], req_in};
         strb_sync <= {strb_sync[SYNC_STAGES-2:0], strb_in};
         strb_d    <= strb_sync[SYNC_STAGES-1];
      end
   end

   assign req_s     = req_sync[SYNC_STAGES-1];
   assign strb_s    = strb_sync[SYNC_STAGES-1];
   assign strb_edge = (strb_s != strb_d);

   // Admission needs room for a whole burst so the FIFO can never overflow
   assign space_ok = ((FIFO_DEPTH - int'(fifo_level)) >= BURST_LEN);

   assign push = (state == RECEIVE) && strb_edge;
   assign pop  = ready_in && valid_out;

   // ------------------------------------------------------------------
   // Burst control FSM with registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rdy_out    <= 1'b0;
         ack_out    <= 1'b0;
         burst_done <= 1'b0;
         err_out    <= 2'b00;
         wrd_cnt    <= '0;
         tmo_cnt    <= '0;
      end else begin
         burst_done <= 1'b0;
         case (state)
            IDLE: begin
               if (req_s && space_ok) begin
                  state   <= RECEIVE;
                  rdy_out <= 1'b1;
                  err_out <= 2'b00;
                  wrd_cnt <= '0;
                  tmo_cnt <= '0;
               end
            end

            RECEIVE: begin
               if (strb_edge) begin
                  tmo_cnt <= '0;
                  wrd_cnt <= wrd_cnt + 1'b1;
                  if (wrd_cnt == CW'(BURST_LEN - 1)) begin
                     state      <= ACK;
                     rdy_out    <= 1'b0;
                     ack_out    <= 1'b1;
                     burst_done <= 1'b1;
                  end else if (!req_s) begin
                     state      <= IDLE;
                     rdy_out    <= 1'b0;
                     err_out[1] <= 1'b1;
                  end
               end else if (!req_s) begin
                  // Sender gave up mid-burst; words already buffered are kept
                  state      <= IDLE;
                  rdy_out    <= 1'b0;
                  err_out[1] <= 1'b1;
               end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  state      <= ERROR;
                  rdy_out    <= 1'b0;
                  err_out[0] <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            ACK: begin
               if (!req_s) begin
                  state   <= IDLE;
                  ack_out <= 1'b0;
               end
            end

            ERROR: begin
               if (!req_s) begin
                  state <= IDLE;
               end
            end

            default: begin
               state   <= IDLE;
               rdy_out <= 1'b0;
               ack_out <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // First-word-fall-through FIFO
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   assign valid_out = (fifo_level != '0);
   // Head word is masked while empty so stale RAM contents never leak out
   assign data_out  = valid_out ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_fpga_link_receiver.sv
// Directed-sequence bench with random payloads; a queue models the expected
// FIFO contents and a monitor checks every word popped by the consumer.
module tb_fpga_link_receiver;

   logic        clk;
   logic        rst_n;
   logic [31:0] data_in;
   logic        req_in;
   logic        strb_in;
   logic        rdy_out;
   logic        ack_out;
   logic [31:0] data_out;
   logic        valid_out;
   logic        ready_in;
   logic        burst_done;
   logic [1:0]  err_out;
   logic [4:0]  fifo_level;

   int          passes = 0;
   int          fails  = 0;
   int          total  = 0;
   int          bd_cnt = 0;
   int          exp_bd = 0;
   logic [31:0] q[$];

   fpga_link_receiver dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .req_in     (req_in),
      .strb_in    (strb_in),
      .rdy_out    (rdy_out),
      .ack_out    (ack_out),
      .data_out   (data_out),
      .valid_out  (valid_out),
      .ready_in   (ready_in),
      .burst_done (burst_done),
      .err_out    (err_out),
      .fifo_level (fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) begin
         passes++;
      end else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Consumer-side scoreboard: every pop must match the oldest accepted word
   always @(negedge clk) begin
      if (rst_n && burst_done) bd_cnt++;
      if (rst_n && valid_out && ready_in) begin
         if (q.size() == 0) check("phantom_word", {63'd0, valid_out}, 64'd0);
         else               check("pop_data", {32'd0, data_out}, {32'd0, q.pop_front()});
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic send_word(input logic [31:0] d, input bit accepted);
      data_in = d;
      strb_in = ~strb_in;
      if (accepted) q.push_back(d);
      cyc($urandom_range(4, 8));
   endtask

   task automatic wait_rdy(input string tag);
      int n = 0;
      while (!rdy_out && n < 60) begin
         cyc(1);
         n++;
      end
      check(tag, {63'd0, rdy_out}, 64'd1);
   endtask

   task automatic full_burst();
      for (int i = 0; i < 10; i++) send_word($urandom, 1'b1);
      exp_bd++;
   endtask

   initial begin
      rst_n = 1'b0; data_in = '0; req_in = 1'b0; strb_in = 1'b0; ready_in = 1'b0;
      cyc(3);
      check("rst_rdy",   {63'd0, rdy_out},    64'd0);
      check("rst_ack",   {63'd0, ack_out},    64'd0);
      check("rst_valid", {63'd0, valid_out},  64'd0);
      check("rst_data",  {32'd0, data_out},   64'd0);
      check("rst_done",  {63'd0, burst_done}, 64'd0);
      check("rst_err",   {62'd0, err_out},    64'd0);
      check("rst_level", {59'd0, fifo_level}, 64'd0);
      rst_n = 1'b1;
      cyc(3);

      // Basic burst 0x1..0xA with a draining consumer
      ready_in = 1'b1;
      req_in   = 1'b1;
      wait_rdy("b1_rdy");
      for (int i = 1; i <= 10; i++) send_word(32'(i), 1'b1);
      exp_bd++;
      cyc(3);
      check("b1_ack",   {63'd0, ack_out}, 64'd1);
      check("b1_rdy_lo", {63'd0, rdy_out}, 64'd0);
      check("b1_done",  64'(bd_cnt), 64'(exp_bd));
      req_in = 1'b0;
      cyc(5);
      check("b1_ack_lo", {63'd0, ack_out}, 64'd0);
      check("b1_drain", {59'd0, fifo_level}, 64'(q.size()));
      check("b1_empty", 64'(q.size()), 64'd0);

      // Strobes in IDLE and in ACK must be ignored
      ready_in = 1'b0;
      for (int i = 0; i < 3; i++) send_word($urandom, 1'b0);
      check("idle_tog_level", {59'd0, fifo_level}, 64'd0);
      check("idle_tog_valid", {63'd0, valid_out}, 64'd0);
      req_in = 1'b1;
      wait_rdy("b2_rdy");
      full_burst();
      cyc(3);
      check("b2_ack", {63'd0, ack_out}, 64'd1);
      send_word($urandom, 1'b0);
      send_word($urandom, 1'b0);
      check("ack_tog_level", {59'd0, fifo_level}, 64'(q.size()));
      check("ack_tog_held", {63'd0, ack_out}, 64'd1);
      req_in = 1'b0;
      cyc(5);
      check("b2_ack_lo", {63'd0, ack_out}, 64'd0);

      // Admission: 8 words left in the FIFO leaves too little room
      ready_in = 1'b1;
      cyc(2);
      ready_in = 1'b0;
      cyc(2);
      check("adm_level8", {59'd0, fifo_level}, 64'(q.size()));
      req_in = 1'b1;
      cyc(12);
      check("adm_blocked", {63'd0, rdy_out}, 64'd0);
      ready_in = 1'b1;
      cyc(2);
      ready_in = 1'b0;
      wait_rdy("adm_after_pop");
      full_burst();
      cyc(3);
      check("adm_full16", {59'd0, fifo_level}, 64'd16);
      check("adm_model16", 64'(q.size()), 64'd16);
      req_in = 1'b0;
      ready_in = 1'b1;
      cyc(24);
      check("adm_drain", {59'd0, fifo_level}, 64'd0);
      check("adm_bd", 64'(bd_cnt), 64'(exp_bd));

      // Abort: three words then the request goes away
      ready_in = 1'b0;
      req_in   = 1'b1;
      wait_rdy("ab_rdy");
      for (int i = 0; i < 3; i++) send_word($urandom, 1'b1);
      req_in = 1'b0;
      cyc(5);
      check("ab_err",   {62'd0, err_out},    64'd2);
      check("ab_level", {59'd0, fifo_level}, 64'd3);
      check("ab_rdy",   {63'd0, rdy_out},    64'd0);
      check("ab_ack",   {63'd0, ack_out},    64'd0);
      ready_in = 1'b1;
      cyc(6);

      // Timeout: two words then a silent strobe
      req_in = 1'b1;
      wait_rdy("to_rdy");
      cyc(1);
      check("to_err_clr", {62'd0, err_out}, 64'd0);
      send_word($urandom, 1'b1);
      send_word($urandom, 1'b1);
      cyc(900);
      check("to_not_yet", {62'd0, err_out}, 64'd0);
      check("to_rdy_yet", {63'd0, rdy_out}, 64'd1);
      cyc(200);
      check("to_err", {62'd0, err_out}, 64'd1);
      check("to_rdy_lo", {63'd0, rdy_out}, 64'd0);
      check("to_ack_lo", {63'd0, ack_out}, 64'd0);
      cyc(10);
      check("to_stuck", {63'd0, rdy_out}, 64'd0);
      req_in = 1'b0;
      cyc(5);
      req_in = 1'b1;
      wait_rdy("to_recover");
      cyc(1);
      check("to_err_cleared", {62'd0, err_out}, 64'd0);
      full_burst();
      cyc(3);
      check("to_burst_ack", {63'd0, ack_out}, 64'd1);
      req_in = 1'b0;
      cyc(5);

      // Reset mid-burst after five words
      ready_in = 1'b0;
      req_in   = 1'b1;
      wait_rdy("rm_rdy");
      for (int i = 0; i < 5; i++) send_word($urandom, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      q.delete();
      check("rm_rdy0",   {63'd0, rdy_out},    64'd0);
      check("rm_ack0",   {63'd0, ack_out},    64'd0);
      check("rm_valid0", {63'd0, valid_out},  64'd0);
      check("rm_data0",  {32'd0, data_out},   64'd0);
      check("rm_err0",   {62'd0, err_out},    64'd0);
      check("rm_level0", {59'd0, fifo_level}, 64'd0);
      check("rm_done0",  {63'd0, burst_done}, 64'd0);
      cyc(3);
      rst_n = 1'b1;
      ready_in = 1'b1;
      wait_rdy("rm_after_rdy");
      full_burst();
      cyc(3);
      check("rm_ack", {63'd0, ack_out}, 64'd1);
      check("rm_bd", 64'(bd_cnt), 64'(exp_bd));
      req_in = 1'b0;
      cyc(6);
      check("rm_ack_lo", {63'd0, ack_out}, 64'd0);
      check("rm_drain", {59'd0, fifo_level}, 64'd0);
      check("rm_model_empty", 64'(q.size()), 64'd0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/fpga_link_receiver.md
FPGA_LINK_RECEIVER -- requirements
Module: fpga_link_receiver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the link data word.
REQ-002 SHALL have parameter BURST_LEN, default 10, words per burst, range 1..1023.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, power of two, at least BURST_LEN.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, range 2..4, flops per synchroniser.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum idle cycles between words in a burst.
REQ-006 SHALL have ports, clock and reset first:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  DATA_WIDTH  link data from the sender, stable from its strb_in toggle until the next toggle.
- req_in  in  1  asynchronous burst request level.
- strb_in  in  1  asynchronous word strobe; each toggle means one new word.
- rdy_out  out  1  receiver is accepting words.
- ack_out  out  1  burst complete.
- data_out  out  DATA_WIDTH  FIFO head word.
- valid_out  out  1  FIFO not empty.
- ready_in  in  1  consumer pops the FIFO when valid_out is high.
- burst_done  out  1  one-cycle pulse when a burst completes.
- err_out  out  2  sticky errors: bit0 timeout, bit1 abort.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-007 SHALL pass req_in and strb_in through SYNC_STAGES-flop synchronisers; req_s and strb_s are the last stages.
REQ-008 SHALL register strb_s as strb_d every cycle in every state; a strobe edge is strb_s != strb_d.
REQ-009 SHALL implement the states IDLE, RECEIVE, ACK and ERROR, reset to IDLE.
REQ-010 In IDLE, SHALL go to RECEIVE when req_s=1 and free space (FIFO_DEPTH-fifo_level) >= BURST_LEN.
- On entry to RECEIVE, SHALL clear err_out, the word counter and the timeout counter.
REQ-011 SHALL hold rdy_out=1 exactly while in RECEIVE.
- rdy_out SHALL be registered and rise one cycle after the IDLE->RECEIVE decision.
REQ-012 In RECEIVE, on each strobe edge SHALL write data_in to the FIFO, increment the word counter and clear the timeout counter.
REQ-013 SHALL go from RECEIVE to ACK on the edge that makes the word count equal BURST_LEN.
- burst_done SHALL pulse for one cycle in that transition.
REQ-014 In ACK, SHALL hold ack_out=1, and SHALL go to IDLE with ack_out=0 once req_s=0.
REQ-015 If req_s=0 in RECEIVE with count < BURST_LEN, SHALL set err_out[1] and go to IDLE.
- Words already written SHALL stay in the FIFO.
REQ-016 If the timeout counter reaches TIMEOUT_CYCLES in RECEIVE, SHALL set err_out[0] and go to ERROR.
- ERROR SHALL drive rdy_out=0 and ack_out=0, and SHALL go to IDLE once req_s=0.
REQ-017 SHALL ignore strobe edges in IDLE, ACK and ERROR: no write and no counter change.
REQ-018 The FIFO SHALL be first-word-fall-through: a word written in cycle N is visible on data_out/valid_out in cycle N+1.
REQ-019 SHALL pop the FIFO when ready_in && valid_out; ready_in with the FIFO empty SHALL be a no-op.
REQ-020 Simultaneous push and pop SHALL leave fifo_level unchanged.
- Simultaneous push and pop on an empty FIFO SHALL act as push only.
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the free-space admission check guarantees the FIFO never overflows.

Reset
REQ-022 While rst_n=0, SHALL asynchronously force state=IDLE, all synchronisers and strb_d to 0, and the FIFO empty.
- Outputs SHALL be rdy_out=0, ack_out=0, valid_out=0, data_out=0, burst_done=0, err_out=0 and fifo_level=0.
REQ-023 Reset asserted mid-burst SHALL discard the FIFO contents and the partial burst.
- The first burst after release SHALL start only on a fresh req_s=1.

Verification
REQ-024 Default parameters, req_in high, 10 strobe toggles with data 0x1..0xA, ready_in=1:
- rdy_out rises, data_out yields 0x1..0xA in order, one burst_done pulse, ack_out=1.
- Lowering req_in then gives ack_out=0 and state IDLE.
REQ-025 ready_in=0, FIFO holding 8 words, req_in raised: rdy_out stays 0 (8 free < 10).
- Popping 2 words admits the burst.
REQ-026 Three toggles, then req_in dropped: err_out=2'b10, fifo_level=3, state IDLE.
REQ-027 Two toggles, then strb_in held for 1024 cycles: err_out=2'b01, state ERROR.
- Dropping req_in returns to IDLE; the next burst clears err_out.
REQ-028 Strobe toggles in IDLE and during ACK: fifo_level unchanged; no phantom word in the next burst.
REQ-029 rst_n pulsed low mid-burst after 5 words: all outputs 0 immediately; a full burst after release succeeds.
